// File: rtl/fifo_drain_router_pkg.sv
// Shared definitions for the transaction-layer drain router: FSM state encoding,
// default word geometry and port count.
package fifo_drain_router_pkg;

    localparam int NUM_PORTS    = 4;
    localparam int DEF_DATA_W   = 12;
    localparam int DEF_DEST_LSB = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ROUTE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick: first requester strictly after last_grant,
// wrapping 0->1->2->3->0, with last_grant itself as lowest priority.
module rr_arbiter4
    import fifo_drain_router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           last_grant,
    output logic [1:0]           grant,
    output logic                 valid
);

    logic [1:0] idx;

    // Scan from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        grant = 2'd0;
        valid = 1'b0;
        idx   = 2'd0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = last_grant + 2'(k);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_drain_router.sv
// Pops one word at a time from four source FIFOs (round-robin) and pushes it to
// the destination FIFO named by the word's destination field.
module fifo_drain_router
    import fifo_drain_router_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEST_LSB = DEF_DEST_LSB
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_PORTS-1:0]          src_empty,
    input  logic [NUM_PORTS*DATA_W-1:0]   src_data,
    output logic [NUM_PORTS-1:0]          src_pop,
    input  logic [NUM_PORTS-1:0]          dst_almost_full,
    output logic [NUM_PORTS-1:0]          dst_push,
    output logic [DATA_W-1:0]             dst_data,
    output logic                          busy,
    output logic [15:0]                   words_moved,
    output logic [15:0]                   stall_cycles
);

    state_t            state;
    logic [1:0]        grant;
    logic [1:0]        last_grant;
    logic [DATA_W-1:0] hold;
    logic [1:0]        dest;
    logic [1:0]        arb_grant;
    logic              arb_valid;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign dest = hold[DEST_LSB+1:DEST_LSB];

    rr_arbiter4 u_arb (
        .req        (~src_empty),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            grant        <= 2'd0;
            last_grant   <= 2'd3;
            hold         <= '0;
            src_pop      <= '0;
            dst_push     <= '0;
            dst_data     <= '0;
            busy         <= 1'b0;
            words_moved  <= 16'd0;
            stall_cycles <= 16'd0;
        end else begin
            // Both strobes are single-cycle pulses; they clear unless re-armed below.
            src_pop  <= '0;
            dst_push <= '0;
            case (state)
                ST_IDLE: begin
                    if (enable && arb_valid) begin
                        src_pop    <= NUM_PORTS'(1) << arb_grant;
                        grant      <= arb_grant;
                        last_grant <= arb_grant;
                        busy       <= 1'b1;
                        state      <= ST_POP;
                    end
                end
                ST_POP: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Source FIFO's data_out reflects the pop from the previous edge.
                    hold  <= src_data[grant*DATA_W +: DATA_W];
                    state <= ST_ROUTE;
                end
                ST_ROUTE: begin
                    if (!dst_almost_full[dest]) begin
                        dst_push    <= NUM_PORTS'(1) << dest;
                        dst_data    <= hold;
                        words_moved <= words_moved + 16'd1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        stall_cycles <= sat_inc(stall_cycles);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_router.sv
// Directed bench for fifo_drain_router: transfer-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_fifo_drain_router;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [3:0]    src_empty;
    logic [4*DW-1:0] src_data;
    logic [3:0]    src_pop;
    logic [3:0]    dst_almost_full;
    logic [3:0]    dst_push;
    logic [DW-1:0] dst_data;
    logic          busy;
    logic [15:0]   words_moved;
    logic [15:0]   stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    fifo_drain_router #(.DATA_W(DW), .DEST_LSB(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .src_empty       (src_empty),
        .src_data        (src_data),
        .src_pop         (src_pop),
        .dst_almost_full (dst_almost_full),
        .dst_push        (dst_push),
        .dst_data        (dst_data),
        .busy            (busy),
        .words_moved     (words_moved),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is described by its age in cycles since the
    // grant; pop at age 1, capture at age 2, route from age 3 until unblocked.
    int          m_age = 0;
    int          m_src = 0;
    int          m_last = 3;
    logic [DW-1:0] m_word = '0;
    logic [3:0]  m_pop = '0, m_push = '0;
    logic [DW-1:0] m_data = '0;
    logic        m_busy = 1'b0;
    logic [15:0] m_moved = '0, m_stall = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_age = 0; m_last = 3; m_word = '0; m_pop = '0; m_push = '0;
            m_data = '0; m_busy = 1'b0; m_moved = '0; m_stall = '0;
        end else begin
            m_pop  = '0;
            m_push = '0;
            if (m_age == 0) begin
                if (enable && (src_empty != 4'hF)) begin
                    for (int k = 4; k >= 1; k--)
                        if (!src_empty[(m_last + k) % 4]) m_src = (m_last + k) % 4;
                    m_last = m_src;
                    m_pop  = 4'b0001 << m_src;
                    m_busy = 1'b1;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_age == 2) begin
                m_word = src_data[m_src*DW +: DW];
                m_age  = 3;
            end else begin
                if (!dst_almost_full[m_word[11:10]]) begin
                    m_push  = 4'b0001 << m_word[11:10];
                    m_data  = m_word;
                    m_moved = m_moved + 16'd1;
                    m_busy  = 1'b0;
                    m_age   = 0;
                end else if (m_stall != 16'hFFFF) begin
                    m_stall = m_stall + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("src_pop", 32'(src_pop), 32'(m_pop));
        chk("dst_push", 32'(dst_push), 32'(m_push));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("words_moved", 32'(words_moved), 32'(m_moved));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        if (m_push != 4'h0) chk("dst_data", 32'(dst_data), 32'(m_data));
    end

    task automatic wait_pop(output logic [3:0] p);
        p = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (src_pop != 4'h0) begin
                p = src_pop;
                return;
            end
        end
        chk("pop_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_push(output logic [3:0] p, output int n);
        p = '0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (dst_push != 4'h0) begin
                p = dst_push;
                return;
            end
        end
        chk("push_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    logic [3:0] p;
    int         n;
    int         t_prev, t_now, pops_seen;
    logic [1:0] order [8];

    initial begin
        reset = 1'b0; enable = 1'b1; src_empty = 4'h0; dst_almost_full = 4'h0;
        src_data = {12'h7A3, 12'hBC4, 12'hC5A, 12'h012};

        // Reset held with all sources non-empty: nothing may be popped.
        repeat (2) @(negedge clk);
        chk("rst_pop", 32'(src_pop), 32'h0);
        chk("rst_push", 32'(dst_push), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_moved", 32'(words_moved), 32'h0);
        chk("rst_data", 32'(dst_data), 32'h0);

        // Single word from source 1, destination 3.
        src_empty = 4'b1101;
        reset = 1'b1;
        wait_pop(p);
        chk("single_pop", 32'(p), 32'h2);
        src_empty = 4'hF;
        wait_push(p, n);
        chk("single_latency", 32'(n), 32'd3);
        chk("single_push", 32'(p), 32'h8);
        chk("single_data", 32'(dst_data), 32'hC5A);
        chk("single_moved", 32'(words_moved), 32'd1);
        repeat (3) @(negedge clk);

        // Round-robin with every source ready.
        do_reset();
        src_empty = 4'h0;
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            wait_pop(p);
            t_now = int'($time / 10);
            order[i] = (p == 4'h1) ? 2'd0 : (p == 4'h2) ? 2'd1 : (p == 4'h4) ? 2'd2 : 2'd3;
            chk("rr_order", 32'(order[i]), 32'(i % 4));
            if (i > 0) chk("rr_spacing", 32'(t_now - t_prev), 32'd4);
            t_prev = t_now;
            if (i == 7) src_empty = 4'hF;
        end
        wait_push(p, n);
        chk("rr_moved", 32'(words_moved), 32'd8);
        repeat (3) @(negedge clk);

        // Backpressure: destination 2 almost full for five ROUTE cycles.
        do_reset();
        src_data[0 +: DW] = 12'h8AB;
        dst_almost_full = 4'b0100;
        src_empty = 4'b1110;
        wait_pop(p);
        src_empty = 4'hF;
        repeat (7) @(negedge clk);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_nopush", 32'(dst_push), 32'h0);
        dst_almost_full = 4'h0;
        wait_push(p, n);
        chk("bp_push", 32'(p), 32'h4);
        chk("bp_data", 32'(dst_data), 32'h8AB);
        chk("bp_stall", 32'(stall_cycles), 32'd5);
        repeat (3) @(negedge clk);

        // Enable dropped while the word is in WAIT.
        src_data[0 +: DW] = 12'h123;
        src_empty = 4'b1110;
        wait_pop(p);
        @(negedge clk);
        enable = 1'b0;
        wait_push(p, n);
        chk("en_push", 32'(p), 32'h1);
        chk("en_data", 32'(dst_data), 32'h123);
        pops_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (src_pop != 4'h0) pops_seen++;
        end
        chk("en_nopop", 32'(pops_seen), 32'd0);
        enable = 1'b1;
        wait_pop(p);
        chk("en_resume", 32'(p), 32'h1);
        src_empty = 4'hF;
        wait_push(p, n);
        repeat (2) @(negedge clk);

        // Reset while a word is stalled in ROUTE.
        src_data[1*DW +: DW] = 12'h456;
        dst_almost_full = 4'b0010;
        src_empty = 4'b1101;
        wait_pop(p);
        chk("mr_pop", 32'(p), 32'h2);
        src_empty = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        dst_almost_full = 4'h0;
        @(negedge clk);
        chk("mr_push", 32'(dst_push), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_moved", 32'(words_moved), 32'h0);
        chk("mr_stall", 32'(stall_cycles), 32'h0);
        reset = 1'b1;
        src_empty = 4'h0;
        wait_pop(p);
        chk("mr_first", 32'(p), 32'h1);
        src_empty = 4'hF;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
